button_debouncer: RTL and testbench

- Conditions a raw, bouncy button or switch input into a clean single-bit level for the etch-a-sketch controls.
- Sits directly upstream of edge_detector: its debounced output drives edge_detector's signal input, and it shares that block's clk and ena.
- Built from a two-flop synchronizer, a consecutive-sample counter and a 4-state FSM.

---
 rtl/button_debouncer.sv | 113 +++++++++++
 tb/tb_button_debouncer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces a raw button level into a clean registered level.
// Define BUTTON_DEBOUNCER_SYNC_EN to add the two-flop input synchronizer (leave undefined only when raw is already synchronous).
module button_debouncer #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter bit          RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic debounced,
  output logic bouncing
);

  localparam int unsigned     CW   = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam state_t RESET_STATE = RESET_VALUE ? STABLE_HIGH : STABLE_LOW;

  state_t        state;
  logic [CW-1:0] count;
  logic          s;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic s_meta;

  // Runs regardless of ena so a pause never leaves a metastable sample in the path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= RESET_VALUE;
      s      <= RESET_VALUE;
    end else begin
      s_meta <= raw;
      s      <= s_meta;
    end
  end
`else
  assign s = raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RESET_STATE;
      count     <= '0;
      debounced <= RESET_VALUE;
      bouncing  <= 1'b0;
    end else if (ena) begin
      case (state)
        STABLE_LOW: begin
          if (s) begin
            state    <= WAIT_HIGH;
            count    <= ONE;
            bouncing <= 1'b1;
          end else begin
            count <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state    <= STABLE_LOW;
            count    <= '0;
            bouncing <= 1'b0;
          end else if (count == LAST) begin
            state     <= STABLE_HIGH;
            count     <= '0;
            debounced <= 1'b1;
            bouncing  <= 1'b0;
          end else begin
            count <= count + ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state    <= WAIT_LOW;
            count    <= ONE;
            bouncing <= 1'b1;
          end else begin
            count <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state    <= STABLE_HIGH;
            count    <= '0;
            bouncing <= 1'b0;
          end else if (count == LAST) begin
            state     <= STABLE_LOW;
            count     <= '0;
            debounced <= 1'b0;
            bouncing  <= 1'b0;
          end else begin
            count <= count + ONE;
          end
        end
        default: begin
          state     <= RESET_STATE;
          count     <= '0;
          debounced <= RESET_VALUE;
          bouncing  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed vector bench for button_debouncer with BOUNCE_CYCLES=4.
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic raw;
  logic debounced;
  logic bouncing;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .BOUNCE_CYCLES(4),
    .RESET_VALUE  (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .raw      (raw),
    .debounced(debounced),
    .bouncing (bouncing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic raw;
    logic d;
    logic b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic d, input logic b);
    vec_t v;
    v.raw = r;
    v.d   = d;
    v.b   = b;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic exp_d, input logic exp_b);
    checks++;
    if (debounced !== exp_d || bouncing !== exp_b) begin
      errors++;
      $display("FAIL %s: debounced=%b bouncing=%b, expected debounced=%b bouncing=%b",
               name, debounced, bouncing, exp_d, exp_b);
    end
  endtask

  // Expects a press already applied before edge 1: rise on edge SD+4, bouncing on the three edges before it.
  task automatic check_press(input string name);
    for (int k = 1; k <= SD + 5; k++) begin
      step();
      check($sformatf("%s edge %0d", name, k), k >= SD + 4, (k >= SD + 1) && (k < SD + 4));
    end
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b1;
    raw = 1'b1;

    // Reset held with raw high
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset hold", 1'b0, 1'b0);
    end
    rst = 1'b1;
    check_press("press after reset");

    // Return to low before the table
    raw = 1'b0;
    for (int i = 0; i < SD + 4; i++) step();
    check("settled low", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();

    // Rows are expressed at the cycle the FSM consumes raw; DUT output lags by SD.
    for (int g = 0; g < 5; g++) begin
      add(1, 0, 1); add(1, 0, 1); add(1, 0, 1); add(0, 0, 0);
    end
    add(1, 0, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 0, 0);
    add(0, 0, 0); add(0, 0, 0);
    add(1, 0, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(1, 1, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 0, 0);
    add(0, 0, 0);

    for (int i = 0; i < tbl.size() + SD; i++) begin
      raw = (i < tbl.size()) ? tbl[i].raw : tbl[tbl.size() - 1].raw;
      step();
      if (i >= SD) check($sformatf("vector %0d", i - SD), tbl[i - SD].d, tbl[i - SD].b);
      else         check($sformatf("vector lead %0d", i), 1'b0, 1'b0);
    end

    // Enable pause after two counts
    raw = 1'b1;
    for (int i = 0; i < SD + 2; i++) step();
    check("pause count2", 1'b0, 1'b1);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("paused %0d", i), 1'b0, 1'b1);
    end
    ena = 1'b1;
    step();
    check("resume edge 1", 1'b0, 1'b1);
    step();
    check("resume edge 2", 1'b1, 1'b0);

    // Back to low, then reset in the middle of WAIT_HIGH
    raw = 1'b0;
    for (int i = 0; i < SD + 4; i++) step();
    check("release to low", 1'b0, 1'b0);
    step();
    raw = 1'b1;
    for (int i = 0; i < SD + 2; i++) step();
    check("mid wait count2", 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check("async reset mid wait", 1'b0, 1'b0);
    step();
    step();
    check("reset held mid wait", 1'b0, 1'b0);
    rst = 1'b1;
    check_press("press after mid reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
